// File: rtl/align_shift_arbiter_if.sv
// Handshake and data bundle between the two shift requesters, the shared
// alignment shifter and the downstream add/round consumer.
interface align_shift_arbiter_if #(
    parameter int W  = 49,
    parameter int DW = 8
);
    logic          req0_valid;
    logic          req0_ready;
    logic [W-1:0]  req0_mant;
    logic [DW-1:0] req0_dist;

    logic          req1_valid;
    logic          req1_ready;
    logic [W-1:0]  req1_mant;
    logic [DW-1:0] req1_dist;

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_mant;
    logic          out_sticky;
    logic          out_src;

    // Requesters and consumer side.
    modport master (
        output req0_valid, req0_mant, req0_dist,
        input  req0_ready,
        output req1_valid, req1_mant, req1_dist,
        input  req1_ready,
        input  out_valid, out_mant, out_sticky, out_src,
        output out_ready
    );

    // Shifter side.
    modport slave (
        input  req0_valid, req0_mant, req0_dist,
        output req0_ready,
        input  req1_valid, req1_mant, req1_dist,
        output req1_ready,
        output out_valid, out_mant, out_sticky, out_src,
        input  out_ready
    );
endinterface

// File: rtl/align_shift_arbiter.sv
// Shared 49-bit logical right shifter for FP add alignment (req0) and FP
// multiply denormalisation (req1). Round-robin arbitration, operand capture
// with shift clamping, sticky generation and a held valid/ready result.
module align_shift_arbiter #(
    parameter int W   = 49,
    parameter int SHW = 6,
    parameter int DW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    align_shift_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int             MW         = 1 << SHW;
    localparam logic [DW-1:0]  DIST_LIMIT = DW'(W);
    localparam logic [SHW-1:0] AMT_MAX    = {SHW{1'b1}};

    state_t         state_r;
    state_t         state_next_s;
    logic           last_grant_r;
    logic           grant_s;
    logic           hs_s;

    logic [W-1:0]   sel_mant_s;
    logic [DW-1:0]  sel_dist_s;
    logic [SHW-1:0] sel_amt_s;

    logic [W-1:0]   mant_r;
    logic [SHW-1:0] amt_r;
    logic           src_r;

    logic [W-1:0]   shift_mant_s;
    logic           shift_sticky_s;

    logic           out_valid_r;
    logic [W-1:0]   out_mant_r;
    logic           out_sticky_r;
    logic           out_src_r;

    // Mask of the bit positions that fall off the bottom for a given amount.
    // A clamped amount of 63 covers the whole field, so the sticky matches
    // the unclamped distance for any dist >= W.
    function automatic logic [W-1:0] lost_bits_mask(input logic [SHW-1:0] amt);
        logic [MW-1:0] one_v;
        logic [MW-1:0] full_v;
        one_v  = {{(MW-1){1'b0}}, 1'b1};
        full_v = (one_v << amt) - one_v;
        return full_v[W-1:0];
    endfunction

    function automatic logic sticky_of(input logic [W-1:0] mant, input logic [SHW-1:0] amt);
        return |(mant & lost_bits_mask(amt));
    endfunction

    // Round-robin grant; depends only on valids and the previous winner.
    always_comb begin
        grant_s = 1'b0;
        if (bus.req0_valid && !bus.req1_valid) begin
            grant_s = 1'b0;
        end else if (!bus.req0_valid && bus.req1_valid) begin
            grant_s = 1'b1;
        end else if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ~last_grant_r;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign bus.req0_ready = (state_r == IDLE) && !grant_s;
    assign bus.req1_ready = (state_r == IDLE) &&  grant_s;
    assign hs_s           = (state_r == IDLE) && (grant_s ? bus.req1_valid : bus.req0_valid);

    // Operand mux for the granted requester plus shift-amount clamp.
    always_comb begin
        sel_mant_s = '0;
        sel_dist_s = '0;
        sel_amt_s  = '0;
        if (grant_s) begin
            sel_mant_s = bus.req1_mant;
            sel_dist_s = bus.req1_dist;
        end else begin
            sel_mant_s = bus.req0_mant;
            sel_dist_s = bus.req0_dist;
        end
        if (sel_dist_s >= DIST_LIMIT) begin
            sel_amt_s = AMT_MAX;
        end else begin
            sel_amt_s = sel_dist_s[SHW-1:0];
        end
    end

    // Shifter datapath over the captured operand; zeros enter from the top.
    always_comb begin
        shift_mant_s   = mant_r >> amt_r;
        shift_sticky_s = sticky_of(mant_r, amt_r);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic: accept, evaluate, hold until consumed.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (hs_s) begin
                    state_next_s = CAPT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CAPT: begin
                state_next_s = DONE;
            end
            DONE: begin
                if (out_valid_r && bus.out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand capture and arbitration history, updated on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_r       <= '0;
            amt_r        <= '0;
            src_r        <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (hs_s) begin
            mant_r       <= sel_mant_s;
            amt_r        <= sel_amt_s;
            src_r        <= grant_s;
            last_grant_r <= grant_s;
        end
    end

    // Result registers: loaded in CAPT, held through DONE until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_mant_r   <= '0;
            out_sticky_r <= 1'b0;
            out_src_r    <= 1'b0;
        end else if (state_r == CAPT) begin
            out_valid_r  <= 1'b1;
            out_mant_r   <= shift_mant_s;
            out_sticky_r <= shift_sticky_s;
            out_src_r    <= src_r;
        end else if ((state_r == DONE) && out_valid_r && bus.out_ready) begin
            out_valid_r  <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.out_mant   = out_mant_r;
    assign bus.out_sticky = out_sticky_r;
    assign bus.out_src    = out_src_r;

endmodule
